// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller: state enum, opcode/funct fields, ALU operations.
// BNE support is compiled in with MC_CONTROLLER_BNE_EN.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BEQ     = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_BNE     = 4'd12,
    ST_ERROR   = 4'd15
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU operation select from controller state and R-type funct; flags unsupported funct codes.
// The BNE compare path exists only with MC_CONTROLLER_BNE_EN.
module mc_aludec
  import mc_controller_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  logic [2:0] rtype_alu_s;

  // Function-field decode for R-type instructions
  always_comb begin
    funct_illegal = 1'b0;
    rtype_alu_s   = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu_s = ALU_ADD;
      FN_SUB:  rtype_alu_s = ALU_SUB;
      FN_AND:  rtype_alu_s = ALU_AND;
      FN_OR:   rtype_alu_s = ALU_OR;
      FN_SLT:  rtype_alu_s = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

  // Per-state ALU operation; PC increment and address arithmetic all use add
  always_comb begin
    alucontrol = 3'b000;
    case (state)
      ST_FETCH, ST_DECODE, ST_MEMADR, ST_ADDIEX: alucontrol = ALU_ADD;
      ST_EXECUTE: alucontrol = rtype_alu_s;
      ST_BEQ:     alucontrol = ALU_SUB;
`ifdef MC_CONTROLLER_BNE_EN
      ST_BNE:     alucontrol = ALU_SUB;
`endif
      default:    alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore controller with memory handshake timeout and sticky ERROR state.
// Define MC_CONTROLLER_BNE_EN to implement the BNE branch state.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       mem_req,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic       illegal,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [3:0] state_r;
  logic [3:0] state_next_s;
  logic [7:0] wait_r;
  logic       funct_illegal_s;
  logic       timed_out_s;

  mc_aludec u_aludec (
    .state         (state_r),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal_s)
  );

  // Timeout fires only once the counter has already absorbed TIMEOUT unanswered cycles
  assign timed_out_s = !mem_ready && (wait_r >= TIMEOUT_C);
  assign state_o     = state_r;

  // Next-state selection
  always_comb begin
    state_next_s = ST_ERROR;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready)        state_next_s = ST_DECODE;
        else if (timed_out_s) state_next_s = ST_ERROR;
        else                  state_next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next_s = ST_MEMADR;
          OP_RTYPE: begin
            if (funct_illegal_s) state_next_s = ST_ERROR;
            else                 state_next_s = ST_EXECUTE;
          end
          OP_BEQ:  state_next_s = ST_BEQ;
          OP_ADDI: state_next_s = ST_ADDIEX;
          OP_J:    state_next_s = ST_JUMP;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:  state_next_s = ST_BNE;
`endif
          default: state_next_s = ST_ERROR;
        endcase
      end
      ST_MEMADR: begin
        if (op == OP_SW) state_next_s = ST_MEMWR;
        else             state_next_s = ST_MEMRD;
      end
      ST_MEMRD: begin
        if (mem_ready)        state_next_s = ST_MEMWB;
        else if (timed_out_s) state_next_s = ST_ERROR;
        else                  state_next_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready)        state_next_s = ST_FETCH;
        else if (timed_out_s) state_next_s = ST_ERROR;
        else                  state_next_s = ST_MEMWR;
      end
      ST_EXECUTE: state_next_s = ST_ALUWB;
      ST_ADDIEX:  state_next_s = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BEQ, ST_JUMP: state_next_s = ST_FETCH;
`ifdef MC_CONTROLLER_BNE_EN
      ST_BNE:     state_next_s = ST_FETCH;
`endif
      ST_ERROR:   state_next_s = ST_ERROR;
      default:    state_next_s = ST_ERROR;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_FETCH;
    else        state_r <= state_next_s;
  end

  // Memory wait counter, restarted whenever the state moves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         wait_r <= 8'd0;
    else if (state_next_s != state_r)   wait_r <= 8'd0;
    else if (mem_req && !mem_ready)     wait_r <= wait_r + 8'd1;
    else                                wait_r <= wait_r;
  end

  // Moore control decode; irwrite and pcen also qualify on handshake/zero
  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    mem_req  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    illegal  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    case (state_r)
      ST_FETCH: begin
        mem_req = 1'b1;
        irwrite = mem_ready;
        pcen    = mem_ready;
        alusrcb = 2'b01;
      end
      ST_DECODE: alusrcb = 2'b11;
      ST_MEMADR, ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      ST_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      ST_EXECUTE: alusrca = 1'b1;
      ST_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      ST_BEQ: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      ST_ADDIWB: regwrite = 1'b1;
      ST_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
`ifdef MC_CONTROLLER_BNE_EN
      ST_BNE: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        pcen    = !zero;
      end
`endif
      ST_ERROR: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of consecutive cycles it waits for mem_ready before faulting (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-low reset (asserted when 0).
REQ-004 The block SHALL have ports op, input, 6, the opcode, and funct, input, 6, the function field, both taken from the instruction register.
REQ-005 The block SHALL have ports zero, input, 1, the ALU zero flag, and mem_ready, input, 1, the memory handshake acknowledge.
REQ-006 The block SHALL have 1-bit outputs pcen, iord, irwrite, memwrite, mem_req, regdst, memtoreg, regwrite, alusrca and illegal.
REQ-007 The block SHALL have outputs alusrcb (2), pcsrc (2), alucontrol (3) and state_o (4), where state_o is the current state encoding.

Function
REQ-008 The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12, ERROR=15.
REQ-009 The FSM SHALL make these transitions:
- FETCH to DECODE when mem_ready=1.
- DECODE by op: 100011/101011 to MEMADR, 000000 to EXECUTE, 000100 to BEQ, 001000 to ADDIEX, 000010 to JUMP; any other op to ERROR.
- MEMADR to MEMRD (lw) or MEMWR (sw).
- MEMRD to MEMWB when mem_ready=1.
- MEMWR to FETCH when mem_ready=1.
- EXECUTE to ALUWB; ADDIEX to ADDIWB.
- MEMWB, ALUWB, ADDIWB, BEQ, BNE and JUMP to FETCH.
REQ-010 In DECODE with op=000000, a funct value other than 100000, 100010, 100100, 100101 or 101010 SHALL send the FSM to ERROR.
REQ-011 The ALU settings SHALL be:
- FETCH: alusrca=0, alusrcb=01, alucontrol=010.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, alucontrol=010.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111).
- BEQ and BNE: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01.
- JUMP: pcsrc=10.
REQ-012 The memory and write controls SHALL be:
- mem_req=1 in FETCH, MEMRD and MEMWR only.
- iord=1 in MEMRD and MEMWR.
- memwrite=1 in MEMWR.
- irwrite=1 in FETCH only while mem_ready=1.
- regwrite=1 in MEMWB, ALUWB and ADDIWB.
- regdst=1 in ALUWB only; memtoreg=1 in MEMWB only.
REQ-013 pcen SHALL equal (FETCH and mem_ready) OR JUMP OR (BEQ and zero) OR (BNE and not zero).
REQ-014 Every output not listed for a state SHALL be 0 in that state.
REQ-015 A wait counter SHALL increment each cycle mem_req=1 and mem_ready=0, and SHALL clear on any state change.
REQ-016 When the wait counter reaches TIMEOUT with mem_ready still 0, the FSM SHALL enter ERROR on the next edge.
REQ-017 ERROR SHALL assert illegal=1, hold all write enables and mem_req at 0, and be left only by reset.
REQ-018 Instruction latency with zero-wait memory SHALL be:
- lw: 5 cycles.
- sw, R-type and addi: 4 cycles.
- beq, bne and j: 3 cycles.

Reset
REQ-019 Asserting reset SHALL force FETCH and a wait count of 0 immediately, from any state including mid-instruction.
REQ-020 After reset is released, the first rising edge SHALL evaluate FETCH with mem_req=1 and all other outputs per REQ-011 to REQ-014.

Configuration
REQ-021 With macro MC_CONTROLLER_BNE_EN defined, op 000101 in DECODE SHALL go to BNE.
REQ-022 With MC_CONTROLLER_BNE_EN undefined, op 000101 SHALL go to ERROR and the BNE state SHALL not be implemented.

Structure
REQ-023 Package mc_controller_pkg SHALL hold the state enum, the opcode and funct constants, and the alucontrol encodings.
REQ-024 Combinational sub-module mc_aludec SHALL map the state and funct to alucontrol and an illegal-funct flag.

Verification
REQ-025 lw (op=100011) with mem_ready held at 1 -> state_o sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-026 beq with zero=1 -> pcen=1 in state 8; repeating with zero=0 -> pcen=0 throughout state 8.
REQ-027 mem_ready=0 for 3 cycles in FETCH, then 1 -> irwrite=0 for 3 cycles, then irwrite=pcen=1 for one cycle, then state 1.
REQ-028 TIMEOUT=4 with mem_ready stuck at 0 in MEMRD -> ERROR after 4 wait cycles, illegal=1, regwrite never asserted.
REQ-029 op=111111, and separately R-type with funct=000000 -> ERROR from DECODE, illegal=1, held until reset.
REQ-030 Reset asserted in EXECUTE -> state_o=0 immediately and regwrite=0; after release, lw completes normally.
